mmu_array: RTL and testbench

- Parametrised weight-stationary systolic matrix-multiply unit; successor to the fixed 16x16, 8-bit MMU.
- Computes out[j] = sum_i a[i]*W[i][j] per input vector.
- Adds:
  - generic N/width;
  - double-buffered (shadow/active) weight bank with row-sequenced load and swap request;
  - valid/ready handshake;
  - internal input skew and output deskew, so callers see aligned vectors with fixed latency.
- Sits between activation buffer and accumulator/activation stage of the TPU datapath.

---
 rtl/mmu_array_if.sv | 28 ++
 rtl/mmu_array.sv | 172 +++++++++++++++++
 tb/tb_mmu_array.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_array_if.sv
// Handshake bundle for mmu_array: weight-row load channel, swap control, activation input and result output.
// master drives weights/activations and consumes results; slave is the array.
interface mmu_array_if #(
    parameter int N     = 16,
    parameter int DW    = 8,
    parameter int ACC_W = 2*DW + $clog2(N)
) ();
    logic               w_valid;
    logic               w_ready;
    logic [N*DW-1:0]    w_row;
    logic               w_swap;
    logic               w_busy;
    logic               a_valid;
    logic               a_ready;
    logic [N*DW-1:0]    a_vec;
    logic               out_valid;
    logic [N*ACC_W-1:0] out_vec;

    modport master (
        output w_valid, w_row, w_swap, a_valid, a_vec,
        input  w_ready, w_busy, a_ready, out_valid, out_vec
    );

    modport slave (
        input  w_valid, w_row, w_swap, a_valid, a_vec,
        output w_ready, w_busy, a_ready, out_valid, out_vec
    );
endinterface

// File: rtl/mmu_array.sv
// Weight-stationary NxN systolic matmul with shadow/active weights; result appears exactly 2N cycles after accept.
// One vector per cycle; a_ready drops only while a swap waits for the pipeline to drain, w_ready drops once the shadow bank is full.
module mmu_array #(
    parameter int N     = 16,
    parameter int DW    = 8,
    parameter int ACC_W = 2*DW + $clog2(N)
) (
    input  logic       clk,
    input  logic       reset_n,
    mmu_array_if.slave bus
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int VD = 2*N;

    typedef enum logic {LOAD, FULL} ld_state_t;

    ld_state_t            state;
    logic [RW-1:0]        row_cnt;
    logic                 pending;
    logic signed [DW-1:0] w_shadow [N][N];
    logic signed [DW-1:0] w_active [N][N];
    logic [VD-1:0]        vld_pipe;
    logic                 accept;
    logic                 swap_now;

    logic signed [DW-1:0]    row_in [N];
    logic signed [DW-1:0]    act    [N][N];
    logic signed [ACC_W-1:0] psum   [N][N];
    logic signed [DW-1:0]    a_src  [N][N];
    logic signed [ACC_W-1:0] p_src  [N][N];
    logic signed [ACC_W-1:0] col_out [N];

    assign accept      = bus.a_valid && bus.a_ready;
    assign swap_now    = pending && !(|vld_pipe);
    assign bus.w_ready = (state == LOAD);
    assign bus.w_busy  = pending;
    assign bus.a_ready = !pending;

    // Pending can only be raised in FULL, so a swap request during LOAD is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= LOAD;
            row_cnt <= '0;
            pending <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    w_shadow[i][j] <= '0;
                    w_active[i][j] <= '0;
                end
            end
        end else begin
            case (state)
                LOAD: begin
                    if (bus.w_valid) begin
                        for (int j = 0; j < N; j++)
                            w_shadow[row_cnt][j] <= bus.w_row[j*DW +: DW];
                        if (row_cnt == RW'(N-1))
                            state <= FULL;
                        else
                            row_cnt <= row_cnt + 1'b1;
                    end
                end
                FULL: begin
                    if (swap_now) begin
                        w_active <= w_shadow;
                        pending  <= 1'b0;
                        state    <= LOAD;
                        row_cnt  <= '0;
                    end else if (bus.w_swap) begin
                        pending <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Input skew: row i sees its element i cycles after capture; bubbles enter as zero.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic signed [DW-1:0] dly [gi+1];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k <= gi; k++)
                    dly[k] <= '0;
            end else begin
                dly[0] <= accept ? bus.a_vec[gi*DW +: DW] : '0;
                for (int k = 1; k <= gi; k++)
                    dly[k] <= dly[k-1];
            end
        end
        assign row_in[gi] = dly[gi];
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_src[i][0] = row_in[i];
            for (int j = 1; j < N; j++)
                a_src[i][j] = act[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            p_src[0][j] = '0;
            for (int i = 1; i < N; i++)
                p_src[i][j] = psum[i-1][j];
        end
    end

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [DW-1:0]    a,
        input logic signed [DW-1:0]    w
    );
        logic signed [ACC_W-1:0] ax;
        logic signed [ACC_W-1:0] wx;
        ax = ACC_W'(a);
        wx = ACC_W'(w);
        return acc + ax * wx;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    act[i][j]  <= '0;
                    psum[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    act[i][j]  <= a_src[i][j];
                    psum[i][j] <= mac(p_src[i][j], a_src[i][j], w_active[i][j]);
                end
            end
        end
    end

    // Column j leaves the array j cycles after column 0; pad it back into line.
    for (genvar gj = 0; gj < N; gj++) begin : g_deskew
        localparam int D = N - 1 - gj;
        if (D == 0) begin : g_direct
            assign col_out[gj] = psum[N-1][gj];
        end else begin : g_delay
            logic signed [ACC_W-1:0] dly [D];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < D; k++)
                        dly[k] <= '0;
                end else begin
                    dly[0] <= psum[N-1][gj];
                    for (int k = 1; k < D; k++)
                        dly[k] <= dly[k-1];
                end
            end
            assign col_out[gj] = dly[D-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_vec   <= '0;
        end else begin
            vld_pipe      <= {vld_pipe[VD-2:0], accept};
            bus.out_valid <= vld_pipe[VD-1];
            if (vld_pipe[VD-1]) begin
                for (int j = 0; j < N; j++)
                    bus.out_vec[j*ACC_W +: ACC_W] <= col_out[j];
            end
        end
    end
endmodule

// File: tb/tb_mmu_array.sv
// Randomised bench for mmu_array: behavioural matrix/loader model feeds a scoreboard queue checked by an output monitor.
module tb_mmu_array;
    localparam int N     = 16;
    localparam int DW    = 8;
    localparam int ACC_W = 2*DW + $clog2(N);
    localparam int LAT   = 2*N;

    typedef logic [N*DW-1:0]    vec_t;
    typedef logic [N*ACC_W-1:0] res_t;
    typedef struct {
        res_t exp;
        int   acc;
    } sb_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mmu_array_if #(.N(N), .DW(DW), .ACC_W(ACC_W)) bus ();
    mmu_array #(.N(N), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    sb_t  sbq[$];
    res_t last_out;
    int   wsh  [N][N];
    int   wact [N][N];
    int   ld_row;
    bit   ld_full;
    bit   pend;
    int   last_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input res_t act, input res_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic res_t model_out(input vec_t a);
        res_t r;
        int   s;
        r = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++)
                s += int'($signed(a[i*DW +: DW])) * wact[i][j];
            r[j*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        return r;
    endfunction

    function automatic vec_t mk_row(input int kind, input int r);
        vec_t v;
        int   x;
        v = '0;
        for (int j = 0; j < N; j++) begin
            case (kind)
                0:       x = j + 1;
                1:       x = (r == j) ? 1 : 0;
                2:       x = -128;
                3:       x = 127;
                4:       x = (r == j) ? 2 : 0;
                5:       x = int'($urandom_range(0, 255)) - 128;
                default: x = ((r + j) % 7) - 3;
            endcase
            v[j*DW +: DW] = x[DW-1:0];
        end
        return v;
    endfunction

    function automatic vec_t mk_vec(input int kind, input int k);
        vec_t v;
        int   x;
        v = '0;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       x = -(i + 1);
                1:       x = k + i;
                2:       x = k;
                3:       x = -128;
                default: x = int'($urandom_range(0, 255)) - 128;
            endcase
            v[i*DW +: DW] = x[DW-1:0];
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wsh[i][j]  = 0;
                wact[i][j] = 0;
            end
        ld_row   = 0;
        ld_full  = 0;
        pend     = 0;
        last_acc = -1000;
        sbq.delete();
        last_out = '0;
    endtask

    // One clock: check status against the model, drive, apply the edge's effects to the model.
    task automatic step(input bit wv, input vec_t wr, input bit sw, input bit av, input vec_t avv);
        int  e;
        bit  pend_pre;
        bit  full_pre;
        int  acc_pre;
        sb_t s;
        chk("a_ready", res_t'(bus.a_ready), res_t'(!pend));
        chk("w_ready", res_t'(bus.w_ready), res_t'(!ld_full));
        chk("w_busy",  res_t'(bus.w_busy),  res_t'(pend));
        bus.w_valid = wv;
        bus.w_row   = wr;
        bus.w_swap  = sw;
        bus.a_valid = av;
        bus.a_vec   = avv;
        e        = cyc + 1;
        pend_pre = pend;
        full_pre = ld_full;
        acc_pre  = last_acc;
        if (av && !pend_pre) begin
            s.exp = model_out(avv);
            s.acc = e;
            sbq.push_back(s);
            last_acc = e;
        end
        if (wv && !full_pre) begin
            for (int j = 0; j < N; j++)
                wsh[ld_row][j] = int'($signed(wr[j*DW +: DW]));
            if (ld_row == N - 1) ld_full = 1;
            else ld_row++;
        end
        if (pend_pre && e >= acc_pre + LAT + 1) begin
            wact    = wsh;
            pend    = 0;
            ld_full = 0;
            ld_row  = 0;
        end else if (sw && full_pre && !pend_pre) begin
            pend = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic load_matrix(input int kind);
        for (int r = 0; r < N; r++)
            step(1'b1, mk_row(kind, r), 1'b0, 1'b0, '0);
    endtask

    task automatic do_swap();
        int k;
        step(1'b0, '0, 1'b1, 1'b0, '0);
        k = 0;
        while (pend && k < 4*LAT) begin
            idle();
            k++;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 4*LAT) begin
            idle();
            k++;
        end
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    always @(negedge clk) begin
        sb_t s;
        if (reset_n === 1'b1) begin
            if (bus.out_valid) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_out_valid: out_valid=1 with no result expected (cycle %0d)", cyc);
                end else begin
                    s = sbq.pop_front();
                    if (bus.out_vec !== s.exp || cyc != s.acc + LAT) begin
                        n_err++;
                        $display("FAIL result: got %0h at latency %0d, expected %0h at latency %0d",
                                 bus.out_vec, cyc - s.acc, s.exp, LAT);
                    end
                    last_out = s.exp;
                end
            end else begin
                n_vec++;
                if (bus.out_vec !== last_out) begin
                    n_err++;
                    $display("FAIL out_hold: got %0h expected %0h (cycle %0d)", bus.out_vec, last_out, cyc);
                end
            end
        end
    end

    initial begin
        int k;
        int guard;
        bit acc;
        reset_n     = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_row   = '0;
        bus.w_swap  = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_vec   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", res_t'(bus.out_valid), '0);
        chk("rst_out_vec",   bus.out_vec, '0);
        chk("rst_w_ready",   res_t'(bus.w_ready), res_t'(1));
        chk("rst_a_ready",   res_t'(bus.a_ready), res_t'(1));
        chk("rst_w_busy",    res_t'(bus.w_busy), '0);
        reset_n = 1'b1;

        // Column-scaled weights against a negative ramp: out[j] = -136*(j+1).
        load_matrix(0);
        do_swap();
        step(1'b0, '0, 1'b0, 1'b1, mk_vec(0, 0));
        drain();

        // Identity weights, back-to-back stream.
        load_matrix(1);
        do_swap();
        for (int v = 0; v < N; v++)
            step(1'b0, '0, 1'b0, 1'b1, mk_vec(1, v));
        drain();

        // Sign-extension extremes.
        load_matrix(2);
        do_swap();
        step(1'b0, '0, 1'b0, 1'b1, mk_vec(3, 0));
        drain();
        load_matrix(3);
        do_swap();
        step(1'b0, '0, 1'b0, 1'b1, mk_vec(3, 0));
        drain();

        // Random weights and vectors with random bubbles.
        load_matrix(5);
        do_swap();
        for (int v = 0; v < 60; v++)
            step(1'b0, '0, 1'b0, ($urandom_range(0, 3) != 0), mk_vec(4, 0));
        drain();

        // Swap to 2*identity in the middle of a stream.
        load_matrix(1);
        do_swap();
        k = 0;
        for (int r = 0; r < N; r++) begin
            step(1'b1, mk_row(4, r), 1'b0, 1'b1, mk_vec(2, k));
            k++;
        end
        step(1'b0, '0, 1'b1, 1'b1, mk_vec(2, k));
        k++;
        guard = 0;
        while (k < 2*N + 8 && guard < 4*LAT) begin
            acc = !pend;
            step(1'b0, '0, 1'b0, 1'b1, mk_vec(2, k));
            if (acc) k++;
            guard++;
        end
        drain();

        // Swap during LOAD, swap on the last beat, and a 17th beat are all ignored.
        step(1'b0, '0, 1'b1, 1'b0, '0);
        idle();
        for (int r = 0; r < N - 1; r++)
            step(1'b1, mk_row(6, r), 1'b0, 1'b0, '0);
        step(1'b1, mk_row(6, N - 1), 1'b1, 1'b0, '0);
        idle();
        step(1'b1, mk_row(2, 0), 1'b0, 1'b0, '0);
        do_swap();
        for (int v = 0; v < 6; v++)
            step(1'b0, '0, 1'b0, 1'b1, mk_vec(4, 0));
        drain();

        // Reset pulse with vectors in flight.
        load_matrix(5);
        do_swap();
        for (int v = 0; v < 5; v++)
            step(1'b0, '0, 1'b0, 1'b1, mk_vec(4, 0));
        bus.a_valid = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_swap  = 1'b0;
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        model_reset();
        chk("mid_rst_out_valid", res_t'(bus.out_valid), '0);
        chk("mid_rst_out_vec",   bus.out_vec, '0);
        chk("mid_rst_w_ready",   res_t'(bus.w_ready), res_t'(1));
        for (int c = 0; c < 3*LAT; c++)
            idle();
        for (int v = 0; v < 8; v++)
            step(1'b0, '0, 1'b0, 1'b1, mk_vec(4, 0));
        drain();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
